ensemble_vote: RTL and testbench
================================

ENSEMBLE_VOTE -- requirements
Module: ensemble_vote

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: tdata width of every stream.
REQ-002 SHALL have parameter KEEP_WIDTH, default 4: tkeep width of every stream.
REQ-003 SHALL have parameter CLASS_WIDTH, default 8: width of the class label, held in tdata[CLASS_WIDTH-1:0].
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of two, at least 2): per-input buffer depth.
REQ-005 SHALL have parameter TIE_SEL, default 2 (range 0..2): index of the input whose label wins a three-way split.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have, for each i in 1..3, ports s_axis_tdata_i (in, DATA_WIDTH), s_axis_tkeep_i (in, KEEP_WIDTH), s_axis_tvalid_i (in, 1), s_axis_tready_i (out, 1) and s_axis_tlast_i (in, 1), fed by classifier i.
REQ-009 SHALL have ports m_axis_tdata (out, DATA_WIDTH), m_axis_tkeep (out, KEEP_WIDTH), m_axis_tvalid (out, 1), m_axis_tready (in, 1) and m_axis_tlast (out, 1): the ensemble decision stream.
REQ-010 SHALL have port vote_count (out, 32): number of decisions emitted.
REQ-011 SHALL have port split_count (out, 32): number of decisions that were three-way splits.

Function
REQ-012 Input i SHALL be buffered in its own FIFO storing {tlast, label}; s_axis_tready_i = FIFO not full, independent of pop in the same cycle.
REQ-013 Input tkeep SHALL be ignored.
REQ-014 A vote SHALL fire in the cycle where all three FIFOs are non-empty AND the output register is empty or handshaking (m_axis_tvalid & m_axis_tready); all three FIFOs pop together.
REQ-015 Majority rule: if two or more labels are equal, output that label; agree = 3 if all equal, else 2. If all differ, output the label of input TIE_SEL with agree = 1.
REQ-016 Output tdata layout SHALL be [CLASS_WIDTH-1:0] label; [CLASS_WIDTH+1:CLASS_WIDTH] agree; [CLASS_WIDTH+2] last_mismatch; all other bits 0.
REQ-017 m_axis_tlast SHALL be the OR of the three popped tlast bits; last_mismatch = 1 when those bits are not all equal.
REQ-018 m_axis_tkeep SHALL be all ones whenever m_axis_tvalid = 1.
REQ-019 The output register SHALL hold tdata and tlast stable while m_axis_tvalid = 1 and m_axis_tready = 0.
REQ-020 Latency SHALL be 2 cycles: beats accepted on all inputs at edge N with empty FIFOs give m_axis_tvalid = 1 after edge N+1.
REQ-021 Throughput SHALL be one decision per cycle when inputs are valid and m_axis_tready = 1.
REQ-022 vote_count SHALL increment by 1 per vote fire; split_count SHALL increment by 1 per fire with agree = 1; both wrap modulo 2^32.
REQ-023 Simultaneous push and pop on one FIFO SHALL leave its occupancy unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 A FIFO that is full SHALL stall only its own input; the other inputs keep filling until their FIFOs are full.

Reset
REQ-025 While rst_n = 0 at a clock edge, the block SHALL clear all FIFO pointers and occupancies, m_axis_tvalid, m_axis_tdata, m_axis_tlast, vote_count and split_count to 0.
REQ-026 The s_axis_tready_i outputs SHALL read 1 in the first cycle after reset is released.
REQ-027 Reset applied mid-stream SHALL discard all buffered and held beats, with no partial output.

Structure
REQ-028 Package ensemble_pkg SHALL hold CLASS_WIDTH, the tdata field offsets and the agree codes (AGREE_ALL = 3, AGREE_TWO = 2, AGREE_SPLIT = 1).
REQ-029 Sub-module ensemble_fifo (synchronous, parameterised width and depth, full/empty flags) SHALL be instantiated three times; the vote logic and output register live in ensemble_vote.

Verification
REQ-030 Labels 5,5,5 together, tready = 1 -> label 5, agree 3, tlast 0, valid exactly 2 cycles later; vote_count = 1.
REQ-031 Labels 3,7,3 -> label 3, agree 2; labels 1,2,4 with TIE_SEL = 2 -> label 4, agree 1, split_count = 1.
REQ-032 m_axis_tready = 0, send 6 beats per input (FIFO_DEPTH 4) -> each tready low after 4 accepted plus 1 held in the output register; on release all beats come out in order and none are lost.
REQ-033 Input 2 delayed 10 cycles vs inputs 1 and 3 -> no output until input 2 arrives, then correctly paired decisions.
REQ-034 tlast 1,0,1 -> m_axis_tlast = 1, last_mismatch = 1.
REQ-035 rst_n low for 1 cycle with 2 beats buffered and output stalled -> m_axis_tvalid = 0 and counters = 0 next cycle; the next beats give fresh results.

Source files
------------

// File: rtl/ensemble_pkg.sv
// rtl/ensemble_pkg.sv - shared constants and agree codes for the ensemble voter
package ensemble_pkg;

    localparam int CLASS_WIDTH = 8;
    localparam int AGREE_WIDTH = 2;

    typedef enum logic [AGREE_WIDTH-1:0] {
        AGREE_SPLIT = 2'd1,
        AGREE_TWO   = 2'd2,
        AGREE_ALL   = 2'd3
    } agree_t;

    // Decision tdata fields sit directly above the label.
    function automatic int agree_lsb(input int class_width);
        return class_width;
    endfunction

    function automatic int mismatch_bit(input int class_width);
        return class_width + AGREE_WIDTH;
    endfunction

endpackage

// File: rtl/ensemble_fifo.sv
// rtl/ensemble_fifo.sv - synchronous power-of-two FIFO with full/empty flags
module ensemble_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ensemble_vote.sv
// rtl/ensemble_vote.sv - three-way majority voter over buffered classifier streams
module ensemble_vote #(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = 4,
    parameter int CLASS_WIDTH = ensemble_pkg::CLASS_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIE_SEL     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
    input  logic                  s_axis_tvalid_1,
    output logic                  s_axis_tready_1,
    input  logic                  s_axis_tlast_1,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
    input  logic                  s_axis_tvalid_2,
    output logic                  s_axis_tready_2,
    input  logic                  s_axis_tlast_2,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_3,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_3,
    input  logic                  s_axis_tvalid_3,
    output logic                  s_axis_tready_3,
    input  logic                  s_axis_tlast_3,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [31:0]           vote_count,
    output logic [31:0]           split_count
);

    import ensemble_pkg::*;

    localparam int AGREE_LSB = agree_lsb(CLASS_WIDTH);
    localparam int MM_BIT    = mismatch_bit(CLASS_WIDTH);
    localparam int EW        = CLASS_WIDTH + 1;

    logic [2:0]       tvalid_v;
    logic [2:0]       full_v;
    logic [2:0]       empty_v;
    logic [2:0]       last_v;
    logic [EW-1:0]    wdata_v [3];
    logic [EW-1:0]    rdata_v [3];
    logic [CLASS_WIDTH-1:0] lbl [3];
    logic             fire;
    agree_t           agree;
    logic [CLASS_WIDTH-1:0] win_label;
    logic [DATA_WIDTH-1:0]  vote_tdata;
    logic             unused_bits;

    // tkeep is meaningless for a label stream; upper tdata bits are don't-care.
    assign unused_bits = ^{s_axis_tkeep_1, s_axis_tkeep_2, s_axis_tkeep_3,
                           s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3};

    assign tvalid_v   = {s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1};
    assign wdata_v[0] = {s_axis_tlast_1, s_axis_tdata_1[CLASS_WIDTH-1:0]};
    assign wdata_v[1] = {s_axis_tlast_2, s_axis_tdata_2[CLASS_WIDTH-1:0]};
    assign wdata_v[2] = {s_axis_tlast_3, s_axis_tdata_3[CLASS_WIDTH-1:0]};

    assign s_axis_tready_1 = ~full_v[0];
    assign s_axis_tready_2 = ~full_v[1];
    assign s_axis_tready_3 = ~full_v[2];

    assign fire = ~|empty_v & (~m_axis_tvalid | m_axis_tready);

    for (genvar i = 0; i < 3; i++) begin : g_in
        ensemble_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (tvalid_v[i]),
            .wdata (wdata_v[i]),
            .pop   (fire),
            .rdata (rdata_v[i]),
            .full  (full_v[i]),
            .empty (empty_v[i])
        );
        assign lbl[i]    = rdata_v[i][CLASS_WIDTH-1:0];
        assign last_v[i] = rdata_v[i][CLASS_WIDTH];
    end

    always_comb begin
        agree      = AGREE_SPLIT;
        win_label  = lbl[TIE_SEL];
        vote_tdata = '0;
        if (lbl[0] == lbl[1] || lbl[0] == lbl[2]) begin
            win_label = lbl[0];
            agree     = (lbl[0] == lbl[1] && lbl[0] == lbl[2]) ? AGREE_ALL : AGREE_TWO;
        end else if (lbl[1] == lbl[2]) begin
            win_label = lbl[1];
            agree     = AGREE_TWO;
        end
        vote_tdata[CLASS_WIDTH-1:0]             = win_label;
        vote_tdata[AGREE_LSB +: AGREE_WIDTH]    = agree;
        vote_tdata[MM_BIT]                      = (last_v != 3'b000) && (last_v != 3'b111);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            vote_count    <= '0;
            split_count   <= '0;
        end else begin
            if (fire) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= vote_tdata;
                m_axis_tlast  <= |last_v;
                vote_count    <= vote_count + 32'd1;
                if (agree == AGREE_SPLIT) begin
                    split_count <= split_count + 32'd1;
                end
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tkeep = {KEEP_WIDTH{m_axis_tvalid}};

endmodule

// File: tb/tb_ensemble_vote.sv
// tb/tb_ensemble_vote.sv - directed self-checking bench for ensemble_vote
module tb_ensemble_vote;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] td [3];
    logic [2:0]  tv;
    logic [2:0]  tl;
    logic [3:0]  tk = 4'h5;
    logic [2:0]  tr;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [31:0] vote_count;
    logic [31:0] split_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ensemble_vote dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tdata_1  (td[0]),
        .s_axis_tkeep_1  (tk),
        .s_axis_tvalid_1 (tv[0]),
        .s_axis_tready_1 (tr[0]),
        .s_axis_tlast_1  (tl[0]),
        .s_axis_tdata_2  (td[1]),
        .s_axis_tkeep_2  (tk),
        .s_axis_tvalid_2 (tv[1]),
        .s_axis_tready_2 (tr[1]),
        .s_axis_tlast_2  (tl[1]),
        .s_axis_tdata_3  (td[2]),
        .s_axis_tkeep_3  (tk),
        .s_axis_tvalid_3 (tv[2]),
        .s_axis_tready_3 (tr[2]),
        .s_axis_tlast_3  (tl[2]),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .vote_count      (vote_count),
        .split_count     (split_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vd(input int label, input int agree, input bit mm);
        logic [31:0] r;
        r       = '0;
        r[7:0]  = label[7:0];
        r[9:8]  = agree[1:0];
        r[10]   = mm;
        return r;
    endfunction

    task automatic drive(input int a, input int b, input int c,
                         input logic la, input logic lb, input logic lc, input logic v);
        td[0] = 32'(a) | 32'hABCD_0000;
        td[1] = 32'(b);
        td[2] = 32'(c);
        tl    = {lc, lb, la};
        tv    = {v, v, v};
    endtask

    // Beat k: inputs 1,2 carry 20+k, input 3 carries 60+k, so a correct pairing gives 20+k/agree 2.
    task automatic run_beats(input int n, input int d2, input int stall);
        int idx [3];
        int got;
        int first;
        int cyc;
        logic [2:0] rdy;
        logic [2:0] vld;
        idx   = '{0, 0, 0};
        got   = 0;
        first = -1;
        cyc   = 0;
        m_axis_tready = (stall == 0);
        while (got < n && cyc < 300) begin
            for (int i = 0; i < 3; i++) begin
                tv[i] = (idx[i] < n) && !(i == 1 && cyc < d2);
                td[i] = 32'((i == 2) ? 60 + idx[i] : 20 + idx[i]);
                tl[i] = (idx[i] == n - 1);
            end
            if (stall > 0 && cyc == stall) begin
                check("bp_idx1", 32'(idx[0]), 32'd5);
                check("bp_idx2", 32'(idx[1]), 32'd5);
                check("bp_idx3", 32'(idx[2]), 32'd5);
                check("bp_tready", {29'd0, tr}, 32'd0);
                check("bp_held_valid", {31'd0, m_axis_tvalid}, 32'd1);
                m_axis_tready = 1'b1;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("stream_data", m_axis_tdata, vd(20 + got, 2, 1'b0));
                check("stream_last", {31'd0, m_axis_tlast}, {31'd0, got == n - 1});
                if (first < 0) first = cyc;
                got++;
            end
            rdy = tr;
            vld = tv;
            tick();
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (vld[i] && rdy[i]) idx[i]++;
            end
        end
        tv = 3'b000;
        check("stream_count", 32'(got), 32'(n));
        if (stall == 0) check("stream_first_cycle", 32'(first), 32'(d2 + 2));
    endtask

    initial begin
        rst_n = 1'b0;
        m_axis_tready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("rst_valid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_data", m_axis_tdata, 32'd0);
        check("rst_votes", vote_count, 32'd0);
        check("rst_splits", split_count, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_tready", {29'd0, tr}, 32'd7);

        // 5,5,5: valid exactly two edges after acceptance
        drive(5, 5, 5, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("lat_not_yet", {31'd0, m_axis_tvalid}, 32'd0);
        tick();
        check("lat_valid", {31'd0, m_axis_tvalid}, 32'd1);
        check("all_data", m_axis_tdata, vd(5, 3, 1'b0));
        check("all_last", {31'd0, m_axis_tlast}, 32'd0);
        check("all_keep", {28'd0, m_axis_tkeep}, 32'hF);
        check("all_votes", vote_count, 32'd1);
        tick();
        check("all_drain", {31'd0, m_axis_tvalid}, 32'd0);

        // 3,7,3 then 1,2,4 back to back
        drive(3, 7, 3, 0, 0, 0, 1);
        tick();
        drive(1, 2, 4, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("two_data", m_axis_tdata, vd(3, 2, 1'b0));
        tick();
        check("split_valid", {31'd0, m_axis_tvalid}, 32'd1);
        check("split_data", m_axis_tdata, vd(4, 1, 1'b0));
        check("split_count", split_count, 32'd1);
        check("split_votes", vote_count, 32'd3);
        tick();

        // tlast handling: 1,0,1 mismatch then 1,1,1 agreement
        drive(9, 9, 2, 1, 0, 1, 1);
        tick();
        drive(2, 9, 9, 1, 1, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("mm_data", m_axis_tdata, vd(9, 2, 1'b1));
        check("mm_last", {31'd0, m_axis_tlast}, 32'd1);
        tick();
        check("lastall_data", m_axis_tdata, vd(9, 2, 1'b0));
        check("lastall_last", {31'd0, m_axis_tlast}, 32'd1);
        check("lastall_votes", vote_count, 32'd5);
        tick();

        run_beats(6, 0, 12);
        check("bp_votes", vote_count, 32'd11);
        run_beats(3, 10, 0);
        check("delay_votes", vote_count, 32'd14);
        check("delay_splits", split_count, 32'd1);
        m_axis_tready = 1'b1;
        tick();

        // Reset with one beat held and two buffered
        m_axis_tready = 1'b0;
        drive(11, 11, 11, 0, 0, 0, 1);
        tick();
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("mid_held", {31'd0, m_axis_tvalid}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", {31'd0, m_axis_tvalid}, 32'd0);
        check("mid_rst_votes", vote_count, 32'd0);
        check("mid_rst_splits", split_count, 32'd0);
        check("mid_rst_tready", {29'd0, tr}, 32'd7);
        m_axis_tready = 1'b1;
        drive(7, 7, 7, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("mid_flushed", {31'd0, m_axis_tvalid}, 32'd0);
        tick();
        check("mid_fresh_data", m_axis_tdata, vd(7, 3, 1'b0));
        check("mid_fresh_votes", vote_count, 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
